// File: rtl/sdhci_cmd_status.sv
// Command-path status tracker: follows one command through send, response and
// optional R1b busy phase (SDHCI_CMD_BUSY_CHECK_EN) and emits hw2reg write strobes.
module sdhci_cmd_status #(
  parameter int unsigned RSP_TIMEOUT_TICKS  = 64,
  parameter int unsigned BUSY_TIMEOUT_TICKS = 65535,
  parameter int unsigned CNT_W              = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sd_tick_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [5:0] cmd_index_i,
  input  logic [1:0] rsp_type_i,
  input  logic       index_check_en_i,
  input  logic       crc_check_en_i,
  input  logic       tx_done_i,
  input  logic       rsp_valid_i,
  input  logic [5:0] rsp_index_i,
  input  logic       rsp_crc_ok_i,
  input  logic       rsp_end_bit_ok_i,
  input  logic       dat0_i,
  input  logic       abort_i,
  output logic       cmd_complete_de_o,
  output logic       err_de_o,
  output logic [4:0] err_o,
  output logic       inhibit_cmd_d_o,
  output logic       inhibit_cmd_de_o,
  output logic       inhibit_dat_d_o,
  output logic       inhibit_dat_de_o
);

`ifdef SDHCI_CMD_BUSY_CHECK_EN
  localparam bit BUSY_EN = 1'b1;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, WAIT_BUSY} state_e;
`else
  localparam bit BUSY_EN = 1'b0;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_e;
  logic unused_dat0;
  assign unused_dat0 = dat0_i;
`endif

  localparam int unsigned CNT_MAX_TICKS =
    (RSP_TIMEOUT_TICKS > BUSY_TIMEOUT_TICKS) ? RSP_TIMEOUT_TICKS : BUSY_TIMEOUT_TICKS;
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX_TICKS);
  localparam logic [CNT_W-1:0] RSP_LIMIT  = CNT_W'(RSP_TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] BUSY_LIMIT = CNT_W'(BUSY_TIMEOUT_TICKS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [5:0]       idx_q, idx_d;
  logic [1:0]       type_q, type_d;
  logic             idx_chk_q, idx_chk_d;
  logic             crc_chk_q, crc_chk_d;
  logic             ready_q, ready_d;
  logic             complete_q, complete_d;
  logic             err_de_q, err_de_d;
  logic [4:0]       err_q, err_d;
  logic             inh_cmd_val_q, inh_cmd_val_d;
  logic             inh_cmd_de_q, inh_cmd_de_d;
  logic             inh_dat_val_q, inh_dat_val_d;
  logic             inh_dat_de_q, inh_dat_de_d;
  logic [4:0]       rsp_err;

  // Counter holds at the largest configured limit instead of wrapping.
  assign cnt_inc = (cnt_q >= CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    type_d        = type_q;
    idx_chk_d     = idx_chk_q;
    crc_chk_d     = crc_chk_q;
    complete_d    = 1'b0;
    err_de_d      = 1'b0;
    err_d         = '0;
    inh_cmd_val_d = 1'b0;
    inh_cmd_de_d  = 1'b0;
    inh_dat_val_d = 1'b0;
    inh_dat_de_d  = 1'b0;
    rsp_err       = '0;

    if (abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      if (state_q != IDLE) begin
        inh_cmd_de_d = 1'b1;
        inh_dat_de_d = BUSY_EN;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid_i && ready_q) begin
            idx_d         = cmd_index_i;
            type_d        = (!BUSY_EN && rsp_type_i == 2'b11) ? 2'b10 : rsp_type_i;
            idx_chk_d     = index_check_en_i && (rsp_type_i != 2'b01);
            crc_chk_d     = crc_check_en_i;
            inh_cmd_val_d = 1'b1;
            inh_cmd_de_d  = 1'b1;
            inh_dat_val_d = BUSY_EN && (rsp_type_i == 2'b11);
            inh_dat_de_d  = BUSY_EN && (rsp_type_i == 2'b11);
            state_d       = SEND;
          end
        end
        SEND: begin
          if (tx_done_i) begin
            if (type_q == 2'b00) begin
              complete_d   = 1'b1;
              inh_cmd_de_d = 1'b1;
              state_d      = IDLE;
            end else begin
              cnt_d   = '0;
              state_d = WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (sd_tick_i) cnt_d = cnt_inc;
          // A response landing on the limit tick takes precedence over the timeout.
          if (rsp_valid_i) begin
            rsp_err = {1'b0,
                       idx_chk_q && (rsp_index_i != idx_q),
                       !rsp_end_bit_ok_i,
                       crc_chk_q && !rsp_crc_ok_i,
                       1'b0};
            inh_cmd_de_d = 1'b1;
            state_d      = IDLE;
            if (|rsp_err) begin
              err_de_d     = 1'b1;
              err_d        = rsp_err;
              inh_dat_de_d = BUSY_EN && (type_q == 2'b11);
            end else begin
              complete_d = 1'b1;
`ifdef SDHCI_CMD_BUSY_CHECK_EN
              if (type_q == 2'b11) begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
              end
`endif
            end
          end else if (cnt_d >= RSP_LIMIT) begin
            err_de_d     = 1'b1;
            err_d        = 5'b00001;
            inh_cmd_de_d = 1'b1;
            inh_dat_de_d = BUSY_EN && (type_q == 2'b11);
            state_d      = IDLE;
          end
        end
`ifdef SDHCI_CMD_BUSY_CHECK_EN
        WAIT_BUSY: begin
          if (dat0_i) begin
            inh_dat_de_d = 1'b1;
            state_d      = IDLE;
          end else begin
            if (sd_tick_i) cnt_d = cnt_inc;
            if (cnt_d >= BUSY_LIMIT) begin
              err_de_d     = 1'b1;
              err_d        = 5'b10000;
              inh_dat_de_d = 1'b1;
              state_d      = IDLE;
            end
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      type_q        <= '0;
      idx_chk_q     <= 1'b0;
      crc_chk_q     <= 1'b0;
      ready_q       <= 1'b1;
      complete_q    <= 1'b0;
      err_de_q      <= 1'b0;
      err_q         <= '0;
      inh_cmd_val_q <= 1'b0;
      inh_cmd_de_q  <= 1'b0;
      inh_dat_val_q <= 1'b0;
      inh_dat_de_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      type_q        <= type_d;
      idx_chk_q     <= idx_chk_d;
      crc_chk_q     <= crc_chk_d;
      ready_q       <= ready_d;
      complete_q    <= complete_d;
      err_de_q      <= err_de_d;
      err_q         <= err_d;
      inh_cmd_val_q <= inh_cmd_val_d;
      inh_cmd_de_q  <= inh_cmd_de_d;
      inh_dat_val_q <= inh_dat_val_d;
      inh_dat_de_q  <= inh_dat_de_d;
    end
  end

  assign cmd_ready_o       = ready_q;
  assign cmd_complete_de_o = complete_q;
  assign err_de_o          = err_de_q;
  assign err_o             = err_q;
  assign inhibit_cmd_d_o   = inh_cmd_val_q;
  assign inhibit_cmd_de_o  = inh_cmd_de_q;
  assign inhibit_dat_d_o   = inh_dat_val_q;
  assign inhibit_dat_de_o  = inh_dat_de_q;

endmodule
